// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded-instruction inputs from ID, registered
// controls and operands towards EX, and the combinational front-end stall.
// master = ID/front-end side, slave = the id_ex_stage register itself.
interface id_ex_stage_if;
    logic        flush;
    logic        idValid;
    logic [5:0]  idOpcode;
    logic [5:0]  idFunct;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic [4:0]  idRd;
    logic [31:0] idReadData1;
    logic [31:0] idReadData2;
    logic [15:0] idImm16;

    logic        stallOut;
    logic        exValid;
    logic [3:0]  aluOperation;
    logic [31:0] readData1;
    logic [31:0] mux2Out;
    logic [31:0] exWriteData;
    logic [4:0]  exDestReg;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exMemWrite;

    modport master (
        output flush, idValid, idOpcode, idFunct, idRs, idRt, idRd,
               idReadData1, idReadData2, idImm16,
        input  stallOut, exValid, aluOperation, readData1, mux2Out,
               exWriteData, exDestReg, exRegWrite, exMemRead, exMemWrite
    );

    modport slave (
        input  flush, idValid, idOpcode, idFunct, idRs, idRt, idRd,
               idReadData1, idReadData2, idImm16,
        output stallOut, exValid, aluOperation, readData1, mux2Out,
               exWriteData, exDestReg, exRegWrite, exMemRead, exMemWrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit MIPS datapath.
// Decodes the ID instruction into ALU opcode, operand B and memory/write-back
// controls, registers them for EX, and squashes taken-branch flushes.
// Optional feature macro: HAZARD_DETECT_EN enables load-use detection
// (stallOut plus bubble insertion); without it stallOut is tied low and
// software has to schedule load-delay slots.
module id_ex_stage (
    input logic         clk_i,
    input logic         reset_i,
    id_ex_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    logic [3:0]  dec_alu;
    logic        dec_use_imm;
    logic [4:0]  dec_dest;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_uses_rt;
    logic [31:0] sext_imm;
    logic [31:0] dec_operand_b;

    logic        hazard;
    logic        bubble;

    logic        ex_valid_q,     ex_valid_d;
    logic [3:0]  alu_op_q,       alu_op_d;
    logic [31:0] read_data1_q,   read_data1_d;
    logic [31:0] mux2_out_q,     mux2_out_d;
    logic [31:0] write_data_q,   write_data_d;
    logic [4:0]  dest_reg_q,     dest_reg_d;
    logic        reg_write_q,    reg_write_d;
    logic        mem_read_q,     mem_read_d;
    logic        mem_write_q,    mem_write_d;

    assign sext_imm      = {{16{bus.idImm16[15]}}, bus.idImm16};
    assign dec_operand_b = dec_use_imm ? sext_imm : bus.idReadData2;

    // Instruction decode; anything unrecognised falls through as a nop.
    // Non-writing instructions carry dest 0 so the EX register stays clean.
    always_comb begin
        dec_alu       = ALU_ADD;
        dec_use_imm   = 1'b0;
        dec_dest      = 5'd0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_uses_rt   = 1'b0;
        case (bus.idOpcode)
            OP_RTYPE: begin
                dec_uses_rt = 1'b1;
                if (bus.idFunct == FN_ADD) begin
                    dec_dest      = bus.idRd;
                    dec_reg_write = 1'b1;
                end else if (bus.idFunct == FN_SUB) begin
                    dec_alu       = ALU_SUB;
                    dec_dest      = bus.idRd;
                    dec_reg_write = 1'b1;
                end
            end
            OP_LW: begin
                dec_use_imm   = 1'b1;
                dec_dest      = bus.idRt;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_SW: begin
                dec_use_imm   = 1'b1;
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                dec_use_imm   = 1'b1;
                dec_dest      = bus.idRt;
                dec_reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu     = ALU_SUB;
                dec_uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef HAZARD_DETECT_EN
    // A load in EX whose destination feeds this instruction's source(s).
    assign hazard = ex_valid_q & mem_read_q & (dest_reg_q != 5'd0) & bus.idValid &
                    ((dest_reg_q == bus.idRs) |
                     (dec_uses_rt & (dest_reg_q == bus.idRt)));
`else
    logic unused_hazard_inputs;
    assign hazard               = 1'b0;
    assign unused_hazard_inputs = ^{bus.idRs, dec_uses_rt};
`endif

    // A flush already squashes the consumer, so it also releases the stall.
    assign bubble       = ~bus.idValid | hazard | bus.flush;
    assign bus.stallOut = hazard & ~bus.flush;

    // Next EX contents: bubble or the freshly decoded instruction.
    always_comb begin
        ex_valid_d   = 1'b0;
        alu_op_d     = ALU_ADD;
        read_data1_d = 32'd0;
        mux2_out_d   = 32'd0;
        write_data_d = 32'd0;
        dest_reg_d   = 5'd0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        if (!bubble) begin
            ex_valid_d   = 1'b1;
            alu_op_d     = dec_alu;
            read_data1_d = bus.idReadData1;
            mux2_out_d   = dec_operand_b;
            write_data_d = bus.idReadData2;
            dest_reg_d   = dec_dest;
            reg_write_d  = dec_reg_write & (dec_dest != 5'd0);
            mem_read_d   = dec_mem_read;
            mem_write_d  = dec_mem_write;
        end
    end

    // EX register bank with synchronous reset to an empty slot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_valid_q   <= 1'b0;
            alu_op_q     <= ALU_ADD;
            read_data1_q <= 32'd0;
            mux2_out_q   <= 32'd0;
            write_data_q <= 32'd0;
            dest_reg_q   <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            alu_op_q     <= alu_op_d;
            read_data1_q <= read_data1_d;
            mux2_out_q   <= mux2_out_d;
            write_data_q <= write_data_d;
            dest_reg_q   <= dest_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign bus.exValid      = ex_valid_q;
    assign bus.aluOperation = alu_op_q;
    assign bus.readData1    = read_data1_q;
    assign bus.mux2Out      = mux2_out_q;
    assign bus.exWriteData  = write_data_q;
    assign bus.exDestReg    = dest_reg_q;
    assign bus.exRegWrite   = reg_write_q;
    assign bus.exMemRead    = mem_read_q;
    assign bus.exMemWrite   = mem_write_q;
endmodule
